rib_arbiter_n: RTL and testbench
================================

Name: rib_arbiter_n

Overview:
- Parametrised N-master to 1-slave bus arbiter for the core's memory/peripheral interconnect.
- Successor to the fixed two-port fetch/EX memory front end: arbitrary master count, selectable fixed-priority or round-robin arbitration, explicit slave request/grant/response handshake, and a response timeout with error reporting.
- Sits between core masters (IF, EX, JTAG/DMA) and a single slave port; per-master hold flags feed ctrl.

Parameters:
- NUM_MASTERS, 2: number of master channels, range 2..8.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width.
- ARB_MODE, 1: 0 = fixed priority (index 0 highest); 1 = round-robin.
- TIMEOUT, 256: maximum number of WAIT_RSP cycles before an error response is forced; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- m_req_i  in  NUM_MASTERS  per-master request
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  flattened; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  flattened, same layout
- m_gnt_o  out  NUM_MASTERS  one-hot request accepted this cycle
- m_rvalid_o  out  NUM_MASTERS  one-hot response valid
- m_err_o  out  1  qualifies m_rvalid_o; 1 = timeout error
- m_rdata_o  out  DATA_WIDTH  response data, shared by all masters
- hold_o  out  NUM_MASTERS  hold_o[i] = m_req_i[i] & ~m_gnt_o[i]
- s_req_o  out  1  slave request
- s_we_o  out  1  slave write enable
- s_addr_o  out  ADDR_WIDTH  slave address
- s_wdata_o  out  DATA_WIDTH  slave write data
- s_gnt_i  in  1  slave accepts request
- s_rvalid_i  in  1  slave response (read data or write ack)
- s_rdata_i  in  DATA_WIDTH  slave read data

Behaviour:
- One clock domain. Reset asserts asynchronously, releases synchronously to clk. During and after reset: state=IDLE, owner=0, rr_ptr=0, tmo_cnt=0; all outputs 0.
- States:
  - IDLE: arbitration is active.
  - WAIT_RSP: exactly one transaction is outstanding.
- Arbitration, combinational, IDLE only:
  - winner w = first requesting index.
  - ARB_MODE=0: scan from index 0.
  - ARB_MODE=1: scan from rr_ptr, wrapping NUM_MASTERS-1 -> 0.
- IDLE and any m_req_i:
  - s_req_o=1; s_we_o/s_addr_o/s_wdata_o = channel w; otherwise all 0.
- IDLE and s_req_o & s_gnt_i (transfer):
  - m_gnt_o[w]=1 in the same cycle.
  - Next cycle: owner<=w, state<=WAIT_RSP, tmo_cnt<=0.
  - ARB_MODE=1: rr_ptr<=(w+1) mod NUM_MASTERS, wrapping at NUM_MASTERS-1.
- IDLE, s_req_o=1, s_gnt_i=0: no grant, no state change. The winner is re-evaluated next cycle, so a higher-priority request may preempt it (the request is not locked).
- WAIT_RSP:
  - s_req_o=0; m_gnt_o=0; tmo_cnt increments, saturating.
  - s_rvalid_i=1: m_rvalid_o[owner]=1, m_rdata_o=s_rdata_i, m_err_o=0; state<=IDLE.
  - Else if TIMEOUT!=0 and tmo_cnt==TIMEOUT-1: m_rvalid_o[owner]=1, m_err_o=1, m_rdata_o=0; state<=IDLE.
  - rvalid on the timeout cycle wins; it is a normal response.
- Any s_rvalid_i while IDLE (e.g. a late reply after timeout) is dropped: no m_rvalid_o.
- m_rvalid_o, m_err_o and m_rdata_o are combinational from state/owner/s_rvalid_i, zero-latency pass-through. No new request is issued in the response cycle, so minimum spacing is 2 cycles per transaction.
- Master requirement: a master holds m_req_i and its payload stable until m_gnt_o. Dropping m_req_i before grant is legal and withdraws the request.
- Widths:
  - owner and rr_ptr are $clog2(NUM_MASTERS) bits.
  - tmo_cnt is $clog2(TIMEOUT+1) bits; minimum 1.
- Reset mid-transaction: the outstanding transaction is abandoned and any following slave response is dropped (state is IDLE).

Decomposition:
- defines.v gains `ARB_MODE_FIXED (0) and `ARB_MODE_RR (1), and state encodings `ARB_IDLE / `ARB_WAIT_RSP.
- Sub-module rr_arbiter:
  - Combinational; inputs req vector, start pointer, mode.
  - Outputs one-hot grant plus encoded index.
  - Instantiated once inside rib_arbiter_n.

Test Plan:
- Single master: NUM_MASTERS=2. m_req_i=01, read addr 0x100, s_gnt_i=1, s_rvalid_i one cycle later with 0xDEADBEEF -> m_gnt_o=01 in cycle 0, m_rvalid_o=01 and m_rdata_o=0xDEADBEEF in cycle 1, hold_o=00 throughout.
- Round-robin fairness: ARB_MODE=1, NUM_MASTERS=3, all requesting continuously, slave replies at once -> grant order 0,1,2,0,1,2; hold_o shows the two losers each issue cycle.
- Fixed priority: ARB_MODE=0, masters 0 and 2 requesting continuously -> master 0 granted every issue slot, hold_o[2]=1 steadily.
- Slave backpressure: s_gnt_i=0 for 3 cycles with master 1 requesting; master 0 raises its request in cycle 2 (ARB_MODE=0) -> s_addr_o switches to master 0 and master 0 receives the grant when s_gnt_i rises.
- Timeout: TIMEOUT=4, grant then no s_rvalid_i -> 4th WAIT_RSP cycle gives m_rvalid_o[owner]=1, m_err_o=1, m_rdata_o=0; a late s_rvalid_i 2 cycles later is dropped.
- Reset mid-transaction: assert rst in WAIT_RSP -> all outputs 0 immediately; after release rr_ptr=0 and the following s_rvalid_i is ignored.

Source files
------------

// File: rtl/rib_arbiter_n_pkg.sv
// Shared constants and helpers for the N-master RIB arbiter.
package rib_arbiter_n_pkg;

    // Arbitration modes selectable through the ARB_MODE parameter.
    localparam int unsigned ARB_MODE_FIXED = 0;
    localparam int unsigned ARB_MODE_RR    = 1;

    // Arbiter FSM state encodings.
    localparam logic [0:0] ARB_IDLE     = 1'b0;
    localparam logic [0:0] ARB_WAIT_RSP = 1'b1;

    // Bit width needed to hold values 0..v-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/rib_arbiter_n_rr_arbiter.sv
// Combinational request picker: first requester scanning from a start index.
// In round-robin mode the scan starts at ptr_i and wraps; otherwise at index 0.
module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             rr_mode_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan the request vector once, from the start index with wrap-around.
    always_comb begin : scan
        int unsigned start;
        int unsigned pos;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        start   = rr_mode_i ? 32'(ptr_i) : 32'd0;
        pos     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = start + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!valid_o && req_i[IDX_W'(pos)]) begin
                valid_o              = 1'b1;
                idx_o                = IDX_W'(pos);
                gnt_o[IDX_W'(pos)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rib_arbiter_n.sv
// N-master to 1-slave bus arbiter with one outstanding transaction,
// fixed-priority or round-robin selection and a response timeout.
module rib_arbiter_n
    import rib_arbiter_n_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ARB_MODE    = 1,
    parameter int unsigned TIMEOUT     = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]            m_gnt_o,
    output logic [NUM_MASTERS-1:0]            m_rvalid_o,
    output logic                              m_err_o,
    output logic [DATA_WIDTH-1:0]             m_rdata_o,
    output logic [NUM_MASTERS-1:0]            hold_o,
    output logic                              s_req_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_addr_o,
    output logic [DATA_WIDTH-1:0]             s_wdata_o,
    input  logic                              s_gnt_i,
    input  logic                              s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]             s_rdata_i
);

    localparam int unsigned IDX_W = clog2_min1(NUM_MASTERS);
    localparam int unsigned TMO_W = clog2_min1(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = '1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);
    localparam logic             RR_EN    = (ARB_MODE == ARB_MODE_RR);

    logic [0:0]       state_q,   state_d;
    logic [IDX_W-1:0] owner_q,   owner_d;
    logic [IDX_W-1:0] rr_ptr_q,  rr_ptr_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    logic [NUM_MASTERS-1:0] arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_valid;

    // Winner selection among current requesters.
    rr_arbiter #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i     (m_req_i),
        .ptr_i     (rr_ptr_q),
        .rr_mode_i (RR_EN),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx),
        .valid_o   (arb_valid)
    );

    // State, owner, round-robin pointer and timeout counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Next-state and output decode; all outputs forced low while in reset.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        tmo_cnt_d  = tmo_cnt_q;
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_err_o    = 1'b0;
        m_rdata_o  = '0;
        hold_o     = '0;
        s_req_o    = 1'b0;
        s_we_o     = 1'b0;
        s_addr_o   = '0;
        s_wdata_o  = '0;

        if (!rst) begin
            case (state_q)
                ARB_IDLE: begin
                    if (arb_valid) begin
                        s_req_o   = 1'b1;
                        s_we_o    = m_we_i[arb_idx];
                        s_addr_o  = m_addr_i[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        s_wdata_o = m_wdata_i[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
                        if (s_gnt_i) begin
                            m_gnt_o   = arb_gnt;
                            state_d   = ARB_WAIT_RSP;
                            owner_d   = arb_idx;
                            tmo_cnt_d = '0;
                            if (RR_EN) begin
                                rr_ptr_d = (arb_idx == IDX_LAST) ? '0 : arb_idx + IDX_W'(1);
                            end
                        end
                    end
                end
                ARB_WAIT_RSP: begin
                    if (tmo_cnt_q != TMO_MAX) begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                    if (s_rvalid_i) begin
                        m_rvalid_o[owner_q] = 1'b1;
                        m_rdata_o           = s_rdata_i;
                        state_d             = ARB_IDLE;
                    end else if ((TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST)) begin
                        m_rvalid_o[owner_q] = 1'b1;
                        m_err_o             = 1'b1;
                        state_d             = ARB_IDLE;
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
            hold_o = m_req_i & ~m_gnt_o;
        end
    end

endmodule

// File: tb/tb_rib_arbiter_n.sv
// Bench for rib_arbiter_n: a round-robin and a fixed-priority instance
// share one stimulus stream; each is checked against a transaction model.
module tb_rib_arbiter_n;

    localparam int NM  = 3;
    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic [2:0]  m_req, m_we;
    logic [31:0] addr_a [NM];
    logic [31:0] wd_a   [NM];
    logic [95:0] m_addr, m_wdata;
    logic        s_gnt, s_rvalid;
    logic [31:0] s_rdata;

    logic [2:0]  gnt_r, rv_r, hold_r, gnt_f, rv_f, hold_f;
    logic        err_r, sreq_r, swe_r, err_f, sreq_f, swe_f;
    logic [31:0] rdata_r, saddr_r, swd_r, rdata_f, saddr_f, swd_f;

    int tests = 0;
    int fails = 0;

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            m_addr[i*32 +: 32]  = addr_a[i];
            m_wdata[i*32 +: 32] = wd_a[i];
        end
    end

    rib_arbiter_n #(.NUM_MASTERS(NM), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                    .ARB_MODE(1), .TIMEOUT(TMO)) u_rr (
        .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we),
        .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_gnt_o(gnt_r),
        .m_rvalid_o(rv_r), .m_err_o(err_r), .m_rdata_o(rdata_r),
        .hold_o(hold_r), .s_req_o(sreq_r), .s_we_o(swe_r),
        .s_addr_o(saddr_r), .s_wdata_o(swd_r), .s_gnt_i(s_gnt),
        .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata));

    rib_arbiter_n #(.NUM_MASTERS(NM), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                    .ARB_MODE(0), .TIMEOUT(TMO)) u_fx (
        .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we),
        .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_gnt_o(gnt_f),
        .m_rvalid_o(rv_f), .m_err_o(err_f), .m_rdata_o(rdata_f),
        .hold_o(hold_f), .s_req_o(sreq_f), .s_we_o(swe_f),
        .s_addr_o(saddr_f), .s_wdata_o(swd_f), .s_gnt_i(s_gnt),
        .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Transaction model, index 0 = round-robin instance, 1 = fixed priority.
    int busy [2], owner [2], ptr [2], waitc [2], win [2];
    logic [2:0]  e_gnt [2], e_rv [2], e_hold [2];
    logic        e_err [2], e_sreq [2], e_we [2];
    logic [31:0] e_rdata [2], e_addr [2], e_wd [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic predict(input int d);
        int start;
        int idx;
        int w;
        e_gnt[d] = '0; e_rv[d] = '0; e_hold[d] = '0; e_err[d] = 1'b0;
        e_sreq[d] = 1'b0; e_we[d] = 1'b0; e_rdata[d] = '0; e_addr[d] = '0; e_wd[d] = '0;
        w = -1;
        if (!rst) begin
            if (busy[d] == 0) begin
                start = (d == 0) ? ptr[d] : 0;
                for (int k = 0; k < NM; k++) begin
                    idx = (start + k) % NM;
                    if (w < 0 && m_req[idx[1:0]]) w = idx;
                end
                if (w >= 0) begin
                    e_sreq[d] = 1'b1;
                    e_we[d]   = m_we[w[1:0]];
                    e_addr[d] = addr_a[w];
                    e_wd[d]   = wd_a[w];
                    if (s_gnt) e_gnt[d] = 3'(1 << w);
                end
            end else if (s_rvalid) begin
                e_rv[d]    = 3'(1 << owner[d]);
                e_rdata[d] = s_rdata;
            end else if (waitc[d] == TMO - 1) begin
                e_rv[d]  = 3'(1 << owner[d]);
                e_err[d] = 1'b1;
            end
            e_hold[d] = m_req & ~e_gnt[d];
        end
        win[d] = w;
    endtask

    task automatic advance(input int d);
        if (rst) begin
            busy[d] = 0; owner[d] = 0; ptr[d] = 0; waitc[d] = 0;
        end else if (busy[d] == 0) begin
            if (e_gnt[d] != 0) begin
                busy[d]  = 1;
                owner[d] = win[d];
                waitc[d] = 0;
                if (d == 0) ptr[d] = (win[d] + 1) % NM;
            end
        end else if (e_rv[d] != 0) begin
            busy[d] = 0;
        end else begin
            waitc[d]++;
        end
    endtask

    task automatic check_inst(input int d, input logic [2:0] g, input logic [2:0] rv,
                              input logic [2:0] h, input logic er, input logic sq,
                              input logic we, input logic [31:0] rd,
                              input logic [31:0] ad, input logic [31:0] wd);
        string p;
        p = (d == 0) ? "rr" : "fx";
        chk({p, ".gnt"},    32'(g),  32'(e_gnt[d]));
        chk({p, ".rvalid"}, 32'(rv), 32'(e_rv[d]));
        chk({p, ".err"},    32'(er), 32'(e_err[d]));
        chk({p, ".hold"},   32'(h),  32'(e_hold[d]));
        chk({p, ".s_req"},  32'(sq), 32'(e_sreq[d]));
        chk({p, ".s_we"},   32'(we), 32'(e_we[d]));
        chk({p, ".s_addr"}, ad,      e_addr[d]);
        chk({p, ".s_wdata"}, wd,     e_wd[d]);
        if (e_rv[d] != 0) chk({p, ".rdata"}, rd, e_rdata[d]);
    endtask

    // Check the current cycle against the model, then advance one clock.
    task automatic cycle();
        predict(0);
        predict(1);
        check_inst(0, gnt_r, rv_r, hold_r, err_r, sreq_r, swe_r, rdata_r, saddr_r, swd_r);
        check_inst(1, gnt_f, rv_f, hold_f, err_f, sreq_f, swe_f, rdata_f, saddr_f, swd_f);
        @(posedge clk);
        advance(0);
        advance(1);
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  req;
        logic        sgnt;
        logic        srv;
        logic [31:0] srdata;
        logic [2:0]  gnt_r, gnt_f, rv_r, rv_f;
        logic        err;
        logic [31:0] rdata;
        logic [2:0]  hold_r, hold_f;
        logic [31:0] saddr_r, saddr_f;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [2:0] req, input logic sg, input logic sv, input logic [31:0] sd,
                       input logic [2:0] gr, input logic [2:0] gf, input logic [2:0] vr,
                       input logic [2:0] vf, input logic er, input logic [31:0] rd,
                       input logic [2:0] hr, input logic [2:0] hf,
                       input logic [31:0] ar, input logic [31:0] af);
        vec_t v;
        v.req = req; v.sgnt = sg; v.srv = sv; v.srdata = sd;
        v.gnt_r = gr; v.gnt_f = gf; v.rv_r = vr; v.rv_f = vf;
        v.err = er; v.rdata = rd; v.hold_r = hr; v.hold_f = hf;
        v.saddr_r = ar; v.saddr_f = af;
        vq.push_back(v);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            busy[d] = 0; owner[d] = 0; ptr[d] = 0; waitc[d] = 0; win[d] = -1;
        end
        rst = 1'b1; m_req = '0; m_we = '0; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        for (int i = 0; i < NM; i++) begin
            addr_a[i] = 32'h100 * 32'(i + 1);
            wd_a[i]   = 32'hA0 + 32'(i);
        end

        // Reset state: everything low even with a slave response present.
        @(negedge clk);
        s_rvalid = 1'b1; s_rdata = 32'hFFFF_FFFF;
        #1;
        chk("reset.s_req", 32'(sreq_r | sreq_f), 32'd0);
        chk("reset.rvalid", 32'(rv_r | rv_f), 32'd0);
        cycle();
        s_rvalid = 1'b0;
        cycle();
        rst = 1'b0;

        // req sg sv sdata        gr    gf    rvr   rvf  err rdata        hr    hf    addr_r addr_f
        add(3'b001,1,0,32'h0,        3'b001,3'b001,3'b000,3'b000,0,32'h0,        3'b000,3'b000,32'h100,32'h100);
        add(3'b000,0,1,32'hDEADBEEF, 3'b000,3'b000,3'b001,3'b001,0,32'hDEADBEEF, 3'b000,3'b000,32'h0,  32'h0);
        add(3'b111,1,0,32'h0,        3'b010,3'b001,3'b000,3'b000,0,32'h0,        3'b101,3'b110,32'h200,32'h100);
        add(3'b111,1,1,32'h11111111, 3'b000,3'b000,3'b010,3'b001,0,32'h11111111, 3'b111,3'b111,32'h0,  32'h0);
        add(3'b111,1,0,32'h0,        3'b100,3'b001,3'b000,3'b000,0,32'h0,        3'b011,3'b110,32'h300,32'h100);
        add(3'b111,1,1,32'h22222222, 3'b000,3'b000,3'b100,3'b001,0,32'h22222222, 3'b111,3'b111,32'h0,  32'h0);
        add(3'b111,1,0,32'h0,        3'b001,3'b001,3'b000,3'b000,0,32'h0,        3'b110,3'b110,32'h100,32'h100);
        add(3'b111,1,1,32'h33333333, 3'b000,3'b000,3'b001,3'b001,0,32'h33333333, 3'b111,3'b111,32'h0,  32'h0);
        add(3'b111,1,0,32'h0,        3'b010,3'b001,3'b000,3'b000,0,32'h0,        3'b101,3'b110,32'h200,32'h100);
        add(3'b111,1,1,32'h44444444, 3'b000,3'b000,3'b010,3'b001,0,32'h44444444, 3'b111,3'b111,32'h0,  32'h0);
        add(3'b101,1,0,32'h0,        3'b100,3'b001,3'b000,3'b000,0,32'h0,        3'b001,3'b100,32'h300,32'h100);
        add(3'b101,1,1,32'h55555555, 3'b000,3'b000,3'b100,3'b001,0,32'h55555555, 3'b101,3'b101,32'h0,  32'h0);
        add(3'b101,1,0,32'h0,        3'b001,3'b001,3'b000,3'b000,0,32'h0,        3'b100,3'b100,32'h100,32'h100);
        add(3'b101,1,1,32'h66666666, 3'b000,3'b000,3'b001,3'b001,0,32'h66666666, 3'b101,3'b101,32'h0,  32'h0);
        add(3'b010,0,0,32'h0,        3'b000,3'b000,3'b000,3'b000,0,32'h0,        3'b010,3'b010,32'h200,32'h200);
        add(3'b010,0,0,32'h0,        3'b000,3'b000,3'b000,3'b000,0,32'h0,        3'b010,3'b010,32'h200,32'h200);
        add(3'b011,0,0,32'h0,        3'b000,3'b000,3'b000,3'b000,0,32'h0,        3'b011,3'b011,32'h200,32'h100);
        add(3'b011,1,0,32'h0,        3'b010,3'b001,3'b000,3'b000,0,32'h0,        3'b001,3'b010,32'h200,32'h100);
        add(3'b000,0,1,32'h77777777, 3'b000,3'b000,3'b010,3'b001,0,32'h77777777, 3'b000,3'b000,32'h0,  32'h0);
        add(3'b100,1,0,32'h0,        3'b100,3'b100,3'b000,3'b000,0,32'h0,        3'b000,3'b000,32'h300,32'h300);
        add(3'b000,0,0,32'h0,        3'b000,3'b000,3'b000,3'b000,0,32'h0,        3'b000,3'b000,32'h0,  32'h0);
        add(3'b000,0,0,32'h0,        3'b000,3'b000,3'b000,3'b000,0,32'h0,        3'b000,3'b000,32'h0,  32'h0);
        add(3'b000,0,0,32'h0,        3'b000,3'b000,3'b000,3'b000,0,32'h0,        3'b000,3'b000,32'h0,  32'h0);
        add(3'b000,0,0,32'hBAD0BAD0, 3'b000,3'b000,3'b100,3'b100,1,32'h0,        3'b000,3'b000,32'h0,  32'h0);
        add(3'b000,0,0,32'h0,        3'b000,3'b000,3'b000,3'b000,0,32'h0,        3'b000,3'b000,32'h0,  32'h0);
        add(3'b000,0,1,32'h12345678, 3'b000,3'b000,3'b000,3'b000,0,32'h0,        3'b000,3'b000,32'h0,  32'h0);
        add(3'b001,1,0,32'h0,        3'b001,3'b001,3'b000,3'b000,0,32'h0,        3'b000,3'b000,32'h100,32'h100);
        add(3'b000,0,0,32'h0,        3'b000,3'b000,3'b000,3'b000,0,32'h0,        3'b000,3'b000,32'h0,  32'h0);
        add(3'b000,0,0,32'h0,        3'b000,3'b000,3'b000,3'b000,0,32'h0,        3'b000,3'b000,32'h0,  32'h0);
        add(3'b000,0,0,32'h0,        3'b000,3'b000,3'b000,3'b000,0,32'h0,        3'b000,3'b000,32'h0,  32'h0);
        add(3'b000,0,1,32'hCAFEF00D, 3'b000,3'b000,3'b001,3'b001,0,32'hCAFEF00D, 3'b000,3'b000,32'h0,  32'h0);

        foreach (vq[n]) begin
            m_req = vq[n].req; m_we = '0; s_gnt = vq[n].sgnt;
            s_rvalid = vq[n].srv; s_rdata = vq[n].srdata;
            #1;
            chk($sformatf("vec%0d.gnt_rr", n),  32'(gnt_r),  32'(vq[n].gnt_r));
            chk($sformatf("vec%0d.gnt_fx", n),  32'(gnt_f),  32'(vq[n].gnt_f));
            chk($sformatf("vec%0d.rv_rr", n),   32'(rv_r),   32'(vq[n].rv_r));
            chk($sformatf("vec%0d.rv_fx", n),   32'(rv_f),   32'(vq[n].rv_f));
            chk($sformatf("vec%0d.err_rr", n),  32'(err_r),  32'(vq[n].err));
            chk($sformatf("vec%0d.err_fx", n),  32'(err_f),  32'(vq[n].err));
            chk($sformatf("vec%0d.hold_rr", n), 32'(hold_r), 32'(vq[n].hold_r));
            chk($sformatf("vec%0d.hold_fx", n), 32'(hold_f), 32'(vq[n].hold_f));
            chk($sformatf("vec%0d.addr_rr", n), saddr_r,     vq[n].saddr_r);
            chk($sformatf("vec%0d.addr_fx", n), saddr_f,     vq[n].saddr_f);
            if (vq[n].rv_r != 0) begin
                chk($sformatf("vec%0d.rdata_rr", n), rdata_r, vq[n].rdata);
                chk($sformatf("vec%0d.rdata_fx", n), rdata_f, vq[n].rdata);
            end
            cycle();
        end

        // Reset while a transaction is outstanding.
        m_req = 3'b010; s_gnt = 1'b1; s_rvalid = 1'b0;
        #1;
        chk("rstseq.issue_rr", 32'(gnt_r), 32'(3'b010));
        cycle();
        rst = 1'b1; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h5A5A5A5A;
        #1;
        chk("rstseq.rv_rr", 32'(rv_r), 32'd0);
        chk("rstseq.rv_fx", 32'(rv_f), 32'd0);
        chk("rstseq.rdata_rr", rdata_r, 32'd0);
        cycle();
        rst = 1'b0;
        #1;
        chk("rstseq.late_rv_rr", 32'(rv_r), 32'd0);
        chk("rstseq.late_rv_fx", 32'(rv_f), 32'd0);
        cycle();
        m_req = 3'b111; s_gnt = 1'b1; s_rvalid = 1'b0;
        #1;
        chk("rstseq.ptr0_rr", 32'(gnt_r), 32'(3'b001));
        cycle();
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0BADCAFE;
        #1;
        chk("rstseq.resp_rr", 32'(rv_r), 32'(3'b001));
        cycle();

        // Randomized traffic against the model.
        for (int c = 0; c < 500; c++) begin
            m_req    = 3'($urandom_range(0, 7));
            m_we     = 3'($urandom_range(0, 7));
            for (int i = 0; i < NM; i++) begin
                addr_a[i] = $urandom;
                wd_a[i]   = $urandom;
            end
            s_gnt    = ($urandom % 4) != 0;
            s_rvalid = ($urandom % 3) == 0;
            s_rdata  = $urandom;
            #1;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
